// File: rtl/sprite_scheduler.sv
// sprite_scheduler: starts each sprite engine once per frame and forwards only the
// granted engine's pixels to the VGA adapter. Optional watchdog: SPRITE_SCHED_TIMEOUT_EN.
module sprite_scheduler #(
    parameter int N_SPRITES = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic [N_SPRITES-1:0]   sprite_mask,
    input  logic [N_SPRITES-1:0]   sp_plot,
    input  logic [8*N_SPRITES-1:0] sp_x,
    input  logic [7*N_SPRITES-1:0] sp_y,
    input  logic [3*N_SPRITES-1:0] sp_colour,
    input  logic [N_SPRITES-1:0]   sp_finish,
    output logic [N_SPRITES-1:0]   sp_en,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_GRANT,
        S_BUSY,
        S_ADVANCE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_SPRITES - 1);

    state_t               state, state_nxt;
    logic [3:0]           idx, idx_nxt;
    logic [N_SPRITES-1:0] en_nxt;
    logic                 sel_mask, sel_plot, sel_finish;
    logic [7:0]           sel_x;
    logic [6:0]           sel_y;
    logic [2:0]           sel_colour;
    logic                 forward;
    logic                 timed_out;

    // Per-index mux over the packed buses; everything not at idx is ignored.
    always_comb begin
        sel_mask   = 1'b0;
        sel_plot   = 1'b0;
        sel_finish = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (idx == 4'(i)) begin
                sel_mask   = sprite_mask[i];
                sel_plot   = sp_plot[i];
                sel_finish = sp_finish[i];
                sel_x      = sp_x[8*i +: 8];
                sel_y      = sp_y[7*i +: 7];
                sel_colour = sp_colour[3*i +: 3];
            end
        end
    end

`ifdef SPRITE_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Fires on the TIMEOUT-th BUSY cycle; a real finish in that cycle wins.
    assign timed_out = (state == S_BUSY) && !sel_finish && (wd_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_GRANT)
                wd_cnt <= '0;
            else if (state == S_BUSY)
                wd_cnt <= wd_cnt + 16'd1;
            if (timed_out)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        en_nxt    = '0;
        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    state_nxt = S_SELECT;
                    idx_nxt   = '0;
                end
            end
            S_SELECT: begin
                if (sel_mask)
                    state_nxt = S_GRANT;
                else if (idx == LAST_IDX)
                    state_nxt = S_DONE;
                else
                    idx_nxt = idx + 4'd1;
            end
            S_GRANT:   state_nxt = S_BUSY;
            S_BUSY: begin
                if (sel_finish || timed_out)
                    state_nxt = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SELECT;
                    idx_nxt   = idx + 4'd1;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        // Registered EN is derived from the next state so it is high exactly in GRANT.
        if (state_nxt == S_GRANT) begin
            for (int i = 0; i < N_SPRITES; i++)
                en_nxt[i] = (idx_nxt == 4'(i));
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            idx        <= '0;
            sp_en      <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            sp_en      <= en_nxt;
            frame_done <= (state_nxt == S_DONE);
            if (frame_tick && state != S_IDLE)
                overrun <= 1'b1;
        end
    end

    assign forward = (state == S_GRANT || state == S_BUSY) && !timed_out;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (forward) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_plot   <= sel_plot;
        end else begin
            vga_plot   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: randomized pixel/finish stimulus against a schedule model
// computed from per-sprite grant/finish arithmetic.
module tb_sprite_scheduler;
    localparam int N   = 4;
    localparam int TMO = 20;

    logic         clk = 1'b0;
    logic         resetn;
    logic         frame_tick = 1'b0;
    logic [N-1:0] sprite_mask = '0;
    logic [N-1:0] sp_plot = '0;
    logic [31:0]  sp_x = '0;
    logic [27:0]  sp_y = '0;
    logic [11:0]  sp_colour = '0;
    logic [N-1:0] sp_finish = '0;
    logic [N-1:0] sp_en;
    logic [7:0]   vga_x;
    logic [6:0]   vga_y;
    logic [2:0]   vga_colour;
    logic         vga_plot, frame_done, busy, overrun, timeout_err;

    always #5 clk = ~clk;

    sprite_scheduler #(.N_SPRITES(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .sprite_mask(sprite_mask),
        .sp_plot(sp_plot), .sp_x(sp_x), .sp_y(sp_y), .sp_colour(sp_colour),
        .sp_finish(sp_finish), .sp_en(sp_en), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .frame_done(frame_done),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    int cyc = 0, n_checks = 0, n_fail = 0;
    int tick_cyc = -1, extra_tick_cyc = -1, done_cyc = -1, seen_done = -1;
    int grant[N], fin[N], win_end[N], fin_at[N], dly[N];
    logic [7:0] exp_x = '0;
    logic [6:0] exp_y = '0;
    logic [2:0] exp_col = '0;
    logic       exp_plot = 1'b0, exp_ovr = 1'b0, exp_tmo = 1'b0;
    bit         force3 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            grant[i]   = -1;
            fin[i]     = -1;
            win_end[i] = -1;
            fin_at[i]  = -1;
        end
        tick_cyc       = -1;
        extra_tick_cyc = -1;
        done_cyc       = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, 32'(sp_en), 0);
        check({tag, "_plot"}, 32'(vga_plot), 0);
        check({tag, "_x"}, 32'(vga_x), 0);
        check({tag, "_y"}, 32'(vga_y), 0);
        check({tag, "_col"}, 32'(vga_colour), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
        check({tag, "_tmo"}, 32'(timeout_err), 0);
    endtask

    // One clock: update the pixel/flag model from the cycle just ended, drive new
    // inputs, then check all outputs at the falling edge.
    task automatic run_cycle();
        int fwd;
        logic [N-1:0] exp_en;
        @(posedge clk);
        #1;
        fwd = -1;
        for (int i = 0; i < N; i++)
            if (grant[i] >= 0 && cyc >= grant[i] && cyc <= win_end[i]) fwd = i;
        if (fwd >= 0) begin
            exp_plot = sp_plot[fwd];
            exp_x    = sp_x[8*fwd +: 8];
            exp_y    = sp_y[7*fwd +: 7];
            exp_col  = sp_colour[3*fwd +: 3];
        end else begin
            exp_plot = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (grant[i] >= 0 && cyc == fin[i] && win_end[i] != fin[i]) exp_tmo = 1'b1;
        if (frame_tick && tick_cyc < cyc && cyc <= done_cyc) exp_ovr = 1'b1;

        cyc++;
        frame_tick = (cyc == tick_cyc) || (cyc == extra_tick_cyc);
        sp_plot    = 4'($urandom);
        sp_x       = $urandom;
        sp_y       = 28'($urandom);
        sp_colour  = 12'($urandom);
        if (force3) begin
            sp_plot[3]    = 1'b1;
            sp_x[31:24]   = 8'd99;
            while (sp_x[15:8] == 8'd99) sp_x[15:8] = 8'($urandom);
        end
        sp_finish = '0;
        for (int i = 0; i < N; i++) begin
            if (fin_at[i] == cyc) sp_finish[i] = 1'b1;
            else if (!(grant[i] >= 0 && cyc > grant[i] && cyc <= fin[i]) &&
                     $urandom_range(0, 7) == 0) sp_finish[i] = 1'b1;
        end

        @(negedge clk);
        exp_en = '0;
        for (int i = 0; i < N; i++)
            if (grant[i] == cyc) exp_en[i] = 1'b1;
        check("sp_en", 32'(sp_en), 32'(exp_en));
        check("frame_done", 32'(frame_done), 32'(cyc == done_cyc));
        check("busy", 32'(busy), 32'(tick_cyc < cyc && cyc <= done_cyc));
        check("vga_plot", 32'(vga_plot), 32'(exp_plot));
        check("vga_x", 32'(vga_x), 32'(exp_x));
        check("vga_y", 32'(vga_y), 32'(exp_y));
        check("vga_colour", 32'(vga_colour), 32'(exp_col));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("timeout_err", 32'(timeout_err), 32'(exp_tmo));
        if (frame_done) seen_done = cyc;
        for (int i = 0; i < N; i++)
            if (sp_en[i]) fin_at[i] = cyc + dly[i];
    endtask

    // Schedule from the timing rules: skipped sprite = 1 SELECT cycle; granted sprite
    // with finish at f resumes selection at f+2; the pass ends one cycle after the last step.
    task automatic do_pass(input logic [N-1:0] mask, input int extra_off, input int abort_sprite);
        int cur;
        sprite_mask = mask;
        tick_cyc    = cyc + 1;
        cur         = tick_cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                grant[i] = cur + 1;
                if (dly[i] > TMO) begin
                    fin[i]     = grant[i] + TMO;
                    win_end[i] = fin[i] - 1;
                end else begin
                    fin[i]     = grant[i] + dly[i];
                    win_end[i] = fin[i];
                end
                cur = fin[i] + 2;
            end else begin
                grant[i]   = -1;
                fin[i]     = -1;
                win_end[i] = -1;
                cur++;
            end
        end
        done_cyc       = cur;
        extra_tick_cyc = (extra_off > 0) ? tick_cyc + extra_off : -1;
        seen_done      = -1;
        while (cyc < done_cyc + 2) begin
            run_cycle();
            if (abort_sprite >= 0 && cyc == grant[abort_sprite] + 2) begin
                #1 resetn = 1'b0;
                #1 check_all_zero("abort");
                clear_sched();
                exp_x = '0; exp_y = '0; exp_col = '0;
                exp_plot = 1'b0; exp_ovr = 1'b0; exp_tmo = 1'b0;
                frame_tick = 1'b0;
                sp_finish  = '0;
                @(posedge clk);
                cyc++;
                #2 resetn = 1'b1;
                return;
            end
        end
        check("done_cycle", 32'(seen_done), 32'(done_cyc));
        clear_sched();
    endtask

    task automatic rand_dly();
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 12);
    endtask

    initial begin
        clear_sched();
        for (int i = 0; i < N; i++) dly[i] = 10;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
        run_cycle();
        run_cycle();

        do_pass(4'b1111, 0, -1);
        rand_dly();
        do_pass(4'b0101, 0, -1);
        do_pass(4'b0000, 0, -1);
        force3 = 1'b1;
        rand_dly();
        do_pass(4'b0010, 0, -1);
        force3 = 1'b0;
        rand_dly();
        do_pass(4'b1111, 5, -1);
        run_cycle();
        for (int i = 0; i < N; i++) dly[i] = 6;
        do_pass(4'b1111, 0, 1);
        run_cycle();
        rand_dly();
        do_pass(4'b1011, 0, -1);
        for (int k = 0; k < 6; k++) begin
            rand_dly();
            do_pass(4'($urandom), 0, -1);
            if ($urandom_range(0, 1) == 1) run_cycle();
        end
`ifdef SPRITE_SCHED_TIMEOUT_EN
        dly[0] = 3; dly[1] = 4; dly[2] = 1000; dly[3] = 5;
        do_pass(4'b1111, 0, -1);
        run_cycle();
`endif
        run_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
